// File: rtl/aes_pkg.sv
// Shared AES definitions: key width, round count, key type and key-scheduler state encoding.
package aes_pkg;

  localparam int unsigned AES_KEY_W = 128;
  localparam int unsigned AES_NR    = 10;

  typedef logic [127:0] aes_key_t;

  typedef enum logic [1:0] {
    KS_IDLE   = 2'd0,
    KS_EXPAND = 2'd1,
    KS_DONE   = 2'd2
  } aes_ks_state_e;

endpackage

// File: rtl/aes_key_scheduler_if.sv
// Request/response link between the key scheduler (master) and the combinational
// single-round key expansion stage (slave).
interface aes_key_scheduler_if #(
  parameter int unsigned KEY_W = 128
);

  logic [KEY_W-1:0] exp_key;
  logic [3:0]       exp_rnum;
  logic             exp_valid;
  logic [KEY_W-1:0] exp_key_out;
  logic             exp_valid_out;

  modport master (
    output exp_key, exp_rnum, exp_valid,
    input  exp_key_out, exp_valid_out
  );

  modport slave (
    input  exp_key, exp_rnum, exp_valid,
    output exp_key_out, exp_valid_out
  );

endinterface

// File: rtl/aes_key_scheduler_rk_store.sv
// Round-key buffer: NR+1 entries, one write port, synchronous clear and a registered
// read port that returns 0 for addresses above NR.
module aes_rk_store #(
  parameter int unsigned KEY_W = 128,
  parameter int unsigned NR    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [3:0]       wr_addr,
  input  logic [KEY_W-1:0] wr_data,
  input  logic [3:0]       rd_addr,
  output logic [KEY_W-1:0] rd_data
);

  localparam logic [3:0] LAST = 4'(NR);

  logic [KEY_W-1:0] mem [0:NR];

  // The read samples the pre-edge contents, so a same-cycle write is seen one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
      for (int i = 0; i <= int'(NR); i++) mem[i] <= '0;
    end else begin
      rd_data <= (rd_addr <= LAST) ? mem[rd_addr] : '0;
      if (clr) begin
        for (int i = 0; i <= int'(NR); i++) mem[i] <= '0;
      end
      if (wr_en && (wr_addr <= LAST)) mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/aes_key_scheduler.sv
// AES-128 key-expansion controller. Optional stall timeout enabled by defining
// AES_KEY_SCHED_TIMEOUT_EN; otherwise EXPAND waits indefinitely and sched_err is 0.
module aes_key_scheduler
  import aes_pkg::*;
#(
  parameter int unsigned KEY_W = AES_KEY_W,
  parameter int unsigned NR    = AES_NR
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [KEY_W-1:0]           key_in,
  input  logic                       key_load,
  output logic                       key_ready,
  aes_key_scheduler_if.master        exp,
  input  logic [3:0]                 rk_rd_addr,
  output logic [KEY_W-1:0]           rk_rd_data,
  output logic                       sched_done,
  output logic                       sched_err
);

  localparam logic [3:0] LAST = 4'(NR);

  aes_ks_state_e    state;
  logic [KEY_W-1:0] cur_key;
  logic [3:0]       rnum;
  logic             load_ok;
  logic             hit;
  logic             abort;

  assign key_ready     = (state != KS_EXPAND);
  assign sched_done    = (state == KS_DONE);
  assign exp.exp_valid = (state == KS_EXPAND);
  assign exp.exp_key   = cur_key;
  assign exp.exp_rnum  = rnum;

  assign load_ok = key_load && key_ready;
  assign hit     = (state == KS_EXPAND) && exp.exp_valid_out;

`ifdef AES_KEY_SCHED_TIMEOUT_EN
  logic [3:0] stall_cnt;
  logic       err;

  // The fifteenth consecutive stalled cycle triggers the abort.
  assign abort     = (state == KS_EXPAND) && !exp.exp_valid_out && (stall_cnt == 4'd14);
  assign sched_err = err;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      err       <= 1'b0;
    end else begin
      err <= abort;
      if ((state != KS_EXPAND) || exp.exp_valid_out || abort) stall_cnt <= '0;
      else                                                  stall_cnt <= stall_cnt + 4'd1;
    end
  end
`else
  assign abort     = 1'b0;
  assign sched_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= KS_IDLE;
      cur_key <= '0;
      rnum    <= '0;
    end else begin
      case (state)
        KS_IDLE, KS_DONE: begin
          if (key_load) begin
            state   <= KS_EXPAND;
            cur_key <= key_in;
            rnum    <= 4'd1;
          end
        end
        KS_EXPAND: begin
          if (exp.exp_valid_out) begin
            cur_key <= exp.exp_key_out;
            if (rnum == LAST) state <= KS_DONE;
            else              rnum  <= rnum + 4'd1;
          end else if (abort) begin
            state <= KS_IDLE;
          end
        end
        default: state <= KS_IDLE;
      endcase
    end
  end

  aes_rk_store #(
    .KEY_W (KEY_W),
    .NR    (NR)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .clr     (load_ok || abort),
    .wr_en   (load_ok || hit),
    .wr_addr (load_ok ? 4'd0 : rnum),
    .wr_data (load_ok ? key_in : exp.exp_key_out),
    .rd_addr (rk_rd_addr),
    .rd_data (rk_rd_data)
  );

endmodule

// File: doc/aes_key_scheduler.md
# aes_key_scheduler

Sequential controller for AES-128 key expansion. It sits directly upstream of the combinational single-round key expansion stage. It loads a cipher key, drives the expansion stage once per round with the current key and round number, and captures each returned round key. All NR+1 round keys are held in a buffer with a registered read port for the round datapath.

## Interface
- `KEY_W`, 128, key/round-key width; only 128 is supported.
- `NR`, 10, number of rounds; the round counter is 4 bits, so NR ≤ 15.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `key_in`  in  KEY_W  cipher key; sampled when `key_load && key_ready`.
- `key_load`  in  1  request to load `key_in` and start expansion.
- `key_ready`  out  1  high in IDLE and DONE; a load is accepted only while high.
- `exp_key`  out  KEY_W  previous round key driven to the expansion stage.
- `exp_rnum`  out  4  round number driven to the expansion stage (1..NR).
- `exp_valid`  out  1  high while `exp_key`/`exp_rnum` are a live request.
- `exp_key_out`  in  KEY_W  next round key returned by the expansion stage.
- `exp_valid_out`  in  1  `exp_key_out` is valid this cycle.
- `rk_rd_addr`  in  4  round-key read index, 0..NR.
- `rk_rd_data`  out  KEY_W  registered read data; 1-cycle latency.
- `sched_done`  out  1  all NR+1 round keys are stored and stable.
- `sched_err`  out  1  one-cycle pulse on a timeout abort; tied 0 when the timeout feature is compiled out.

## Operation
- States: IDLE, EXPAND, DONE.
- IDLE, on `key_load`:
  - rk[0] ← `key_in`; cur_key ← `key_in`; rnum ← 1.
  - Stored rk[1..NR] are cleared to 0.
  - Next state EXPAND.
- EXPAND:
  - `exp_valid`=1, `exp_key`=cur_key, `exp_rnum`=rnum, all driven from registers.
  - On a cycle with `exp_valid_out`=1: rk[rnum] ← `exp_key_out` and cur_key ← `exp_key_out`.
  - In that same cycle, if rnum==NR go to DONE; otherwise rnum ← rnum+1.
  - A cycle with `exp_valid_out`=0 holds all state.
- DONE:
  - `sched_done`=1, `key_ready`=1, `exp_valid`=0.
  - A new `key_load` re-enters EXPAND exactly as from IDLE; `sched_done` drops the next cycle.
- `key_load` while in EXPAND is ignored (`key_ready`=0).
- `exp_valid_out` outside EXPAND is ignored.
- Read port:
  - `rk_rd_data` ← rk[`rk_rd_addr`] on each clock edge.
  - Addresses above NR return 0.
  - A read and a write to the same entry in the same cycle return the old value (read-before-write).
  - Entries not yet written in the current expansion read 0.

## Timing
- Reset values: state IDLE, `key_ready`=1, `exp_valid`=0, `exp_key`=0, `exp_rnum`=0, `rk_rd_data`=0, `sched_done`=0, `sched_err`=0; all rk entries 0.
- Load accepted at edge E0. EXPAND occupies cycles 1..NR when `exp_valid_out` is held high (combinational expander). rk[NR] is written at edge E(NR). `sched_done`=1 from cycle NR+1.
- Total latency from load to done is NR+1 cycles, plus one cycle per stalled cycle.
- Reset during EXPAND or DONE: the next cycle is IDLE with reset values; no partial key remains.

## Configuration
- `AES_KEY_SCHED_TIMEOUT_EN` defined:
  - A 4-bit stall counter counts consecutive EXPAND cycles with `exp_valid_out`=0.
  - The counter clears on any valid cycle.
  - On reaching 15 the block aborts to IDLE, clears rk, and pulses `sched_err` for one cycle.
- Undefined: no counter; EXPAND waits indefinitely; `sched_err` is constant 0.

## Structure
- Shared package `aes_pkg`:
  - constants `AES_KEY_W`=128 and `AES_NR`=10;
  - `aes_key_t` (logic [127:0]);
  - scheduler state enum `aes_ks_state_e`.
- One sub-module, `aes_rk_store`: NR+1 × KEY_W register file with one write port, a synchronous clear, and a registered read port with out-of-range zeroing.

## Test plan
- Bench models a FIPS-197-correct expander with `exp_valid_out`=1.
- FIPS-197 vector: load 2b7e151628aed2a6abf7158809cf4f3c → rk[1]=a0fafe1788542cb123a339392a6c7605, rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6; `sched_done` rises exactly 11 cycles after the load edge.
- Stalls: drop `exp_valid_out` for 3 cycles at rnum=4 → `exp_rnum` holds at 4; `sched_done` arrives at 14 cycles; all keys unchanged.
- Load ignored: pulse `key_load` with a different key during EXPAND → no effect; rk[0] still holds the first key.
- Reload from DONE with key 0 → `sched_done` drops for 11 cycles; rk[1]=62636363626363636263636362636363.
- Reset at cycle 5 of EXPAND → next cycle `key_ready`=1, `exp_valid`=0, reading address 3 returns 0. Reading address 12 after done returns 0.
- With `AES_KEY_SCHED_TIMEOUT_EN`: hold `exp_valid_out`=0 in EXPAND → `sched_err` pulses once after 15 stalled cycles; state IDLE.
